// File: rtl/dct2d_rowcol_seq.sv
// Row/column sequencer that builds an 8x8 2-D DCT from one shared 8-point 1-D DCT core.
// Pass 1 pushes the 8 input rows through the core into a transpose buffer; pass 2 pushes
// the 8 buffer columns through the core and streams the results downstream.
module dct2d_rowcol_seq #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned ROW_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*IN_W-1:0] in_row,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic [8*IN_W-1:0] core_in,
  input  logic              core_out_valid,
  output logic              core_out_ready,
  input  logic [8*IN_W-1:0] core_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*IN_W-1:0] out_row,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              block_done
);

  typedef enum logic [1:0] {
    StRowIssue,
    StRowWait,
    StColIssue,
    StColWait
  } state_e;

  state_e            state_q;
  logic [2:0]        row_cnt_q;
  logic [2:0]        col_cnt_q;
  logic              block_done_q;
  logic [IN_W-1:0]   tbuf_q [8][8];
  logic [8*IN_W-1:0] col_vec;
  logic [IN_W-1:0]   row_shifted [8];

  // Gather column col_cnt_q of the transpose buffer and scale the incoming pass-1 result.
  always_comb begin
    col_vec = '0;
    for (int k = 0; k < 8; k++) begin
      col_vec[k*IN_W +: IN_W] = tbuf_q[k][col_cnt_q];
      row_shifted[k] = $signed(core_out[k*IN_W +: IN_W]) >>> ROW_SHIFT;
    end
  end

  // Handshake routing; everything except block_done is a function of the current state.
  always_comb begin
    in_ready       = 1'b0;
    core_in_valid  = 1'b0;
    core_in        = col_vec;
    core_out_ready = 1'b0;
    out_valid      = 1'b0;
    out_row        = core_out;
    out_idx        = col_cnt_q;
    out_last       = 1'b0;
    unique case (state_q)
      StRowIssue: begin
        core_in       = in_row;
        core_in_valid = in_valid;
        in_ready      = core_in_ready;
      end
      StRowWait: begin
        core_in        = in_row;
        core_out_ready = 1'b1;
      end
      StColIssue: begin
        core_in_valid = 1'b1;
      end
      StColWait: begin
        out_valid      = core_out_valid;
        core_out_ready = out_ready;
        out_last       = (col_cnt_q == 3'd7) && core_out_valid;
      end
      default: ;
    endcase
    busy       = !((state_q == StRowIssue) && (row_cnt_q == 3'd0));
    block_done = block_done_q;
  end

  // Controller: one core job outstanding at a time, every transition handshake driven.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StRowIssue;
      row_cnt_q    <= 3'd0;
      col_cnt_q    <= 3'd0;
      block_done_q <= 1'b0;
    end else begin
      block_done_q <= 1'b0;
      unique case (state_q)
        StRowIssue: begin
          if (in_valid && core_in_ready) state_q <= StRowWait;
        end
        StRowWait: begin
          if (core_out_valid) begin
            if (row_cnt_q == 3'd7) begin
              row_cnt_q <= 3'd0;
              state_q   <= StColIssue;
            end else begin
              row_cnt_q <= row_cnt_q + 3'd1;
              state_q   <= StRowIssue;
            end
          end
        end
        StColIssue: begin
          if (core_in_ready) state_q <= StColWait;
        end
        StColWait: begin
          if (core_out_valid && out_ready) begin
            if (col_cnt_q == 3'd7) begin
              col_cnt_q    <= 3'd0;
              block_done_q <= 1'b1;
              state_q      <= StRowIssue;
            end else begin
              col_cnt_q <= col_cnt_q + 3'd1;
              state_q   <= StColIssue;
            end
          end
        end
        default: state_q <= StRowIssue;
      endcase
    end
  end

  // Transpose buffer: pass-1 results land in row row_cnt_q; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if ((state_q == StRowWait) && core_out_valid) begin
      for (int k = 0; k < 8; k++) begin
        tbuf_q[row_cnt_q][k] <= row_shifted[k];
      end
    end
  end

endmodule

// File: tb/tb_dct2d_rowcol_seq.sv
// Directed bench: two sequencers (ROW_SHIFT 0 and 1) run in lockstep, each driving an
// identity core model with a programmable latency.
module tb_dct2d_rowcol_seq;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [8*W-1:0] in_row;
  logic           out_ready;

  logic           in_ready       [2];
  logic           core_in_valid  [2];
  logic           core_in_ready  [2];
  logic [8*W-1:0] core_in        [2];
  logic           core_out_valid [2];
  logic           core_out_ready [2];
  logic [8*W-1:0] core_out       [2];
  logic           out_valid      [2];
  logic [8*W-1:0] out_row        [2];
  logic [2:0]     out_idx        [2];
  logic           out_last       [2];
  logic           busy           [2];
  logic           block_done     [2];

  int lat;
  int acc_cnt;
  int n_checks;
  int n_errors;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic           m_busy;
    int             m_cnt;
    logic [8*W-1:0] m_data;

    dct2d_rowcol_seq #(.IN_W(W), .ROW_SHIFT(g)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready[g]),
      .in_row        (in_row),
      .core_in_valid (core_in_valid[g]),
      .core_in_ready (core_in_ready[g]),
      .core_in       (core_in[g]),
      .core_out_valid(core_out_valid[g]),
      .core_out_ready(core_out_ready[g]),
      .core_out      (core_out[g]),
      .out_valid     (out_valid[g]),
      .out_ready     (out_ready),
      .out_row       (out_row[g]),
      .out_idx       (out_idx[g]),
      .out_last      (out_last[g]),
      .busy          (busy[g]),
      .block_done    (block_done[g])
    );

    // Identity core: one job at a time, result after lat cycles, held until taken.
    assign core_in_ready[g]  = !m_busy;
    assign core_out_valid[g] = m_busy && (m_cnt == 0);
    assign core_out[g]       = m_data;

    always @(posedge clk) begin
      if (!rst_n) begin
        m_busy <= 1'b0;
        m_cnt  <= 0;
        m_data <= '0;
      end else if (!m_busy) begin
        if (core_in_valid[g]) begin
          m_busy <= 1'b1;
          m_data <= core_in[g];
          m_cnt  <= lat - 1;
        end
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end else if (core_out_ready[g]) begin
        m_busy <= 1'b0;
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready[0]) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [8*W-1:0] got, input logic [8*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Element k = (base + stp*k) >>> sh, truncated to W bits.
  function automatic logic [8*W-1:0] fill(input int base, input int stp, input int sh);
    logic [8*W-1:0] v;
    int e;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      e = (base + stp * k) >>> sh;
      v[k*W +: W] = W'(e);
    end
    return v;
  endfunction

  task automatic send_row(input logic [8*W-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_row   = d;
    for (int t = 0; t < 200 && !done; t++) begin
      check("out_valid_pass1", {255'd0, out_valid[0]}, '0);
      if (in_ready[0]) done = 1'b1;
      step();
    end
    if (!done) check("row_timeout", '0, 1);
  endtask

  task automatic collect(input int j, input logic [8*W-1:0] e0, input logic [8*W-1:0] e1,
                         input int stall);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      check("in_ready_pass2", {255'd0, in_ready[0]}, '0);
      check("busy_pass2", {255'd0, busy[0]}, 1);
      if (out_valid[0]) begin
        check("beat_row_sh0", out_row[0], e0);
        check("beat_valid_sh1", {255'd0, out_valid[1]}, 1);
        check("beat_row_sh1", out_row[1], e1);
        check("out_idx", {253'd0, out_idx[0]}, j);
        check("out_last", {255'd0, out_last[0]}, {255'd0, j == 7});
        check("block_done_early", {255'd0, block_done[0]}, '0);
        if (j == stall) begin
          out_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            step();
            check("stall_valid", {255'd0, out_valid[0]}, 1);
            check("stall_row", out_row[0], e0);
            check("stall_idx", {253'd0, out_idx[0]}, j);
            check("stall_core_out_ready", {255'd0, core_out_ready[0]}, '0);
          end
          out_ready = 1'b1;
        end
        done = 1'b1;
      end
      step();
    end
    if (!done) check("beat_timeout", '0, 1);
  endtask

  // mode 0: ramp 8r+c, mode 1: all -3, mode 2: all +5.
  task automatic do_block(input int mode, input int stall, input bit hold);
    int a0;
    logic [8*W-1:0] e0, e1;
    a0 = acc_cnt;
    for (int r = 0; r < 8; r++) begin
      case (mode)
        0:       send_row(fill(8 * r, 1, 0));
        1:       send_row(fill(-3, 0, 0));
        default: send_row(fill(5, 0, 0));
      endcase
    end
    if (hold) begin
      in_valid = 1'b1;
      in_row   = fill(0, 1, 0);
    end else begin
      in_valid = 1'b0;
    end
    for (int j = 0; j < 8; j++) begin
      case (mode)
        0: begin e0 = fill(j, 8, 0);  e1 = fill(j, 8, 1);  end
        1: begin e0 = fill(-3, 0, 0); e1 = fill(-3, 0, 1); end
        default: begin e0 = fill(5, 0, 0); e1 = fill(5, 0, 1); end
      endcase
      collect(j, e0, e1, stall);
    end
    check("block_done_sh0", {255'd0, block_done[0]}, 1);
    check("block_done_sh1", {255'd0, block_done[1]}, 1);
    check("rows_consumed", acc_cnt - a0, 8);
    if (hold) check("next_row0_ready", {255'd0, in_ready[0]}, 1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    acc_cnt   = 0;
    lat       = 1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b1;
    repeat (3) step();

    check("rst_in_ready", {255'd0, in_ready[0]}, 1);
    check("rst_core_in_valid", {255'd0, core_in_valid[0]}, '0);
    check("rst_out_valid", {255'd0, out_valid[0]}, '0);
    check("rst_core_out_ready", {255'd0, core_out_ready[0]}, '0);
    check("rst_busy", {255'd0, busy[0]}, '0);
    check("rst_block_done", {255'd0, block_done[0]}, '0);
    in_valid = 1'b1;
    in_row   = fill(7, 3, 0);
    #1;
    check("rst_pass_valid", {255'd0, core_in_valid[0]}, 1);
    check("rst_pass_row", core_in[0], fill(7, 3, 0));
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();

    do_block(0, -1, 1'b0);
    do_block(1, -1, 1'b0);
    do_block(2, -1, 1'b0);
    lat = 4;
    do_block(0, 3, 1'b0);
    lat = 1;
    do_block(0, -1, 1'b1);
    do_block(0, -1, 1'b0);

    for (int r = 0; r < 4; r++) send_row(fill(99, 0, 0));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", {255'd0, busy[0]}, '0);
    check("midrst_out_valid", {255'd0, out_valid[0]}, '0);
    do_block(0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
